rf_port_arbiter: RTL and testbench
==================================

Name: rf_port_arbiter

Overview:
- Round-robin arbiter sharing the 32-entry, 1-write/2-read register-file memory among NREQ requesters.
- Each cycle it grants at most one write and two reads, and drives the memory's write and read ports directly.
- It never issues a read to the address being written in the same cycle, so the memory's collision output stays low. A conflicting read is deferred, not dropped.
- Read data returns on two tagged response lanes one cycle after grant.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DATA_WIDTH, 16: data width; matches the memory.
- ADDR_WIDTH, 5: address width (32 entries).
- IDW, 3: requester-ID width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_WIDTH  flattened address; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NREQ*DATA_WIDTH  flattened write data.
- req_ready  out  NREQ  grant this cycle; the request is consumed when req_valid & req_ready.
- mem_wen, mem_wad, mem_din  out  1/ADDR_WIDTH/DATA_WIDTH  memory write port.
- mem_ren1, mem_rad1, mem_ren2, mem_rad2  out  1/ADDR_WIDTH/1/ADDR_WIDTH  memory read ports.
- mem_dout1, mem_dout2  in  DATA_WIDTH  memory read data, valid the cycle after ren.
- mem_collision  in  1  memory collision flag.
- rsp0_valid, rsp0_id, rsp0_data  out  1/IDW/DATA_WIDTH  response lane 0 (from read port 1).
- rsp1_valid, rsp1_id, rsp1_data  out  1/IDW/DATA_WIDTH  response lane 1 (from read port 2).
- defer_cnt  out  16  saturating count of reads deferred by address conflict.
- err_collision  out  1  sticky; set if mem_collision is ever seen high.

Behaviour:
- State: rr_ptr (IDW bits, range 0..NREQ-1), rsp0/rsp1 valid and id registers, defer_cnt, err_collision.
- Reset (async, resetn=0): rr_ptr=0, rsp*_valid=0, rsp*_id=0, defer_cnt=0, err_collision=0. Because they decode from req_valid, req_ready and the mem enables are 0 while req_valid=0.
- Grant logic is combinational from req_* and rr_ptr. Scan requesters in order rr_ptr, rr_ptr+1, ... mod NREQ:
  - Write slot: the first valid request with we=1 gets the write port (mem_wen=1, mem_wad, mem_din from that requester).
  - Read slots: the first valid read whose address differs from the granted write address goes to port 1; the next such read goes to port 2.
  - Reads beyond two wait.
  - A valid read with addr == granted write addr gets ready=0; this is a deferral.
- Deferral counting: defer_cnt increments by 1 per cycle when at least one read is deferred for conflict. It saturates at 16'hFFFF.
- Read-after-write: a deferred read issues no earlier than the next cycle, so it returns the newly written data.
- Pointer update: if any grant occurs, rr_ptr <= (lowest scan-order granted index + 1) mod NREQ. Otherwise rr_ptr holds.
- Ungranted ports: enable 0, address 0, data 0.
- Response timing: one-cycle latency.
  - rsp0_valid <= mem_ren1 and rsp0_id <= granted index.
  - rsp0_data = mem_dout1, combinational passthrough, qualified by rsp0_valid.
  - Lane 1 is identical using port 2 and mem_dout2.
  - rsp*_valid is a single-cycle pulse per grant. There is no backpressure on responses.
- Same requester: at most one grant per cycle. A requester holding req_valid with an unchanged request is re-granted every cycle.
- Write-only or read-only mixes: two reads plus one write from three different requesters may all be granted in one cycle.
- err_collision is set on any cycle with mem_collision=1 and clears only on reset. A correct design never sets it.
- Reset mid-operation: pending rsp*_valid is cleared immediately (asynchronously). In-flight memory reads are discarded.

Test Plan:
- Single write then read: requester 0 writes A5A5 to addr 7 → cycle n: req_ready[0]=1, mem_wen=1, wad=7. Requester 1 then reads addr 7 → rsp0_valid=1, rsp0_id=1, rsp0_data=A5A5 one cycle after its grant.
- Conflict deferral: requester 0 writes FFFF to addr 4 while requester 1 reads addr 4 in the same cycle → cycle n: ready=0b0001, mem_ren1=0, defer_cnt=1. Cycle n+1: read granted. Cycle n+2: rsp0_data=FFFF, rsp0_id=1. err_collision stays 0.
- Full parallelism: req0 write addr 1, req1 read addr 2, req2 read addr 3, req3 read addr 5, rr_ptr=0 → ready=0b0111, ren1 rad=2, ren2 rad=3. Next cycle rr_ptr=1, and req3 is granted.
- Round-robin fairness: all four requesters continuously read distinct addresses → each is granted in two of every four cycles. No requester waits more than 2 cycles.
- Unwritten read after reset: read addr 3 → rsp0_data=0000. Check all outputs are 0 during and right after resetn=0.
- Reset mid-flight: assert resetn=0 the cycle after a read grant → rsp0_valid=0 immediately, defer_cnt=0, rr_ptr=0.

Source files
------------

// File: rtl/rf_port_arbiter_if.sv
// Signal bundle between the register-file arbiter, its requesters, the 1W/2R memory
// and the two tagged read-response lanes.
interface rf_port_arbiter_if #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int IDW        = 3
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_we;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr;
   logic [NREQ*DATA_WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]            req_ready;

   logic                       mem_wen;
   logic [ADDR_WIDTH-1:0]      mem_wad;
   logic [DATA_WIDTH-1:0]      mem_din;
   logic                       mem_ren1;
   logic [ADDR_WIDTH-1:0]      mem_rad1;
   logic                       mem_ren2;
   logic [ADDR_WIDTH-1:0]      mem_rad2;
   logic [DATA_WIDTH-1:0]      mem_dout1;
   logic [DATA_WIDTH-1:0]      mem_dout2;
   logic                       mem_collision;

   logic                       rsp0_valid;
   logic [IDW-1:0]             rsp0_id;
   logic [DATA_WIDTH-1:0]      rsp0_data;
   logic                       rsp1_valid;
   logic [IDW-1:0]             rsp1_id;
   logic [DATA_WIDTH-1:0]      rsp1_data;

   logic [15:0]                defer_cnt;
   logic                       err_collision;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      input  mem_dout1, mem_dout2, mem_collision,
      output req_ready,
      output mem_wen, mem_wad, mem_din, mem_ren1, mem_rad1, mem_ren2, mem_rad2,
      output rsp0_valid, rsp0_id, rsp0_data, rsp1_valid, rsp1_id, rsp1_data,
      output defer_cnt, err_collision
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      output mem_dout1, mem_dout2, mem_collision,
      input  req_ready,
      input  mem_wen, mem_wad, mem_din, mem_ren1, mem_rad1, mem_ren2, mem_rad2,
      input  rsp0_valid, rsp0_id, rsp0_data, rsp1_valid, rsp1_id, rsp1_data,
      input  defer_cnt, err_collision
   );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter granting one write and two reads per cycle to a 1W/2R register file,
// deferring any read that targets the address being written in the same cycle.
module rf_port_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int IDW        = 3
) (
   input  logic                clk,
   input  logic                resetn,
   rf_port_arbiter_if.master   bus
);
   localparam int NSLOT = 2 ** IDW;

   logic [NSLOT-1:0]      vld;
   logic [NSLOT-1:0]      wr;
   logic [ADDR_WIDTH-1:0] addr_arr [NSLOT];
   logic [DATA_WIDTH-1:0] data_arr [NSLOT];

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] next_ptr;
   logic           wr_hit, rd1_hit, rd2_hit, defer_hit, first_hit;
   logic [IDW-1:0] wr_idx, rd1_idx, rd2_idx, first_idx;
   logic [NSLOT-1:0] grant_vec;

   logic           rsp0_valid, rsp1_valid;
   logic [IDW-1:0] rsp0_id, rsp1_id;
   logic [15:0]    defer_cnt;
   logic           err_collision;

   // Requester tables are padded to a power of two so an IDW-bit index always fits exactly.
   assign vld = NSLOT'(bus.req_valid);
   assign wr  = NSLOT'(bus.req_we);

   for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
      if (i < NREQ) begin : g_live
         assign addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         assign data_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
         assign addr_arr[i] = '0;
         assign data_arr[i] = '0;
      end
   end

   function automatic logic [IDW-1:0] scan_idx(input logic [IDW-1:0] base, input int k);
      logic [IDW:0] s;
      s = {1'b0, base} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      return s[IDW-1:0];
   endfunction

   // Write slot is picked first so that reads can be filtered against its address.
   always_comb begin : grant_logic
      logic [IDW-1:0] idx;
      idx       = '0;
      wr_hit    = 1'b0;
      wr_idx    = '0;
      rd1_hit   = 1'b0;
      rd1_idx   = '0;
      rd2_hit   = 1'b0;
      rd2_idx   = '0;
      defer_hit = 1'b0;
      first_hit = 1'b0;
      first_idx = '0;
      grant_vec = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = scan_idx(rr_ptr, k);
         if (!wr_hit && vld[idx] && wr[idx]) begin
            wr_hit = 1'b1;
            wr_idx = idx;
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         idx = scan_idx(rr_ptr, k);
         if (vld[idx] && !wr[idx]) begin
            if (wr_hit && (addr_arr[idx] == addr_arr[wr_idx])) begin
               defer_hit = 1'b1;
            end else if (!rd1_hit) begin
               rd1_hit = 1'b1;
               rd1_idx = idx;
            end else if (!rd2_hit) begin
               rd2_hit = 1'b1;
               rd2_idx = idx;
            end
         end
      end
      if (wr_hit)  grant_vec[wr_idx]  = 1'b1;
      if (rd1_hit) grant_vec[rd1_idx] = 1'b1;
      if (rd2_hit) grant_vec[rd2_idx] = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         idx = scan_idx(rr_ptr, k);
         if (!first_hit && grant_vec[idx]) begin
            first_hit = 1'b1;
            first_idx = idx;
         end
      end
   end

   assign next_ptr = first_hit ? scan_idx(first_idx, 1) : rr_ptr;

   assign bus.req_ready = grant_vec[NREQ-1:0];
   assign bus.mem_wen   = wr_hit;
   assign bus.mem_wad   = wr_hit  ? addr_arr[wr_idx]  : '0;
   assign bus.mem_din   = wr_hit  ? data_arr[wr_idx]  : '0;
   assign bus.mem_ren1  = rd1_hit;
   assign bus.mem_rad1  = rd1_hit ? addr_arr[rd1_idx] : '0;
   assign bus.mem_ren2  = rd2_hit;
   assign bus.mem_rad2  = rd2_hit ? addr_arr[rd2_idx] : '0;

   // Response tags track the memory's one-cycle read latency; counters are sticky/saturating.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr        <= '0;
         rsp0_valid    <= 1'b0;
         rsp0_id       <= '0;
         rsp1_valid    <= 1'b0;
         rsp1_id       <= '0;
         defer_cnt     <= '0;
         err_collision <= 1'b0;
      end else begin
         rr_ptr     <= next_ptr;
         rsp0_valid <= rd1_hit;
         rsp0_id    <= rd1_idx;
         rsp1_valid <= rd2_hit;
         rsp1_id    <= rd2_idx;
         if (defer_hit && (defer_cnt != 16'hFFFF)) defer_cnt <= defer_cnt + 16'd1;
         if (bus.mem_collision) err_collision <= 1'b1;
      end
   end

   assign bus.rsp0_valid    = rsp0_valid;
   assign bus.rsp0_id       = rsp0_id;
   assign bus.rsp0_data     = rsp0_valid ? bus.mem_dout1 : '0;
   assign bus.rsp1_valid    = rsp1_valid;
   assign bus.rsp1_id       = rsp1_id;
   assign bus.rsp1_data     = rsp1_valid ? bus.mem_dout2 : '0;
   assign bus.defer_cnt     = defer_cnt;
   assign bus.err_collision = err_collision;
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios plus randomized traffic checked against a
// scan-order reference model and a shadow copy of the register-file contents.
module tb_rf_port_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int AW   = 5;
   localparam int IDW  = 3;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rf_port_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDW(IDW)) bus ();

   rf_port_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDW(IDW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // 32-entry memory with registered reads; collision flags a same-cycle read of the write address.
   logic [DW-1:0] mem [32] = '{default: '0};
   always @(posedge clk) begin
      if (bus.mem_wen)  mem[bus.mem_wad] <= bus.mem_din;
      if (bus.mem_ren1) bus.mem_dout1 <= mem[bus.mem_rad1];
      if (bus.mem_ren2) bus.mem_dout2 <= mem[bus.mem_rad2];
   end
   assign bus.mem_collision = bus.mem_wen &&
                              ((bus.mem_ren1 && (bus.mem_rad1 == bus.mem_wad)) ||
                               (bus.mem_ren2 && (bus.mem_rad2 == bus.mem_wad)));

   bit            s_valid [NREQ];
   bit            s_we    [NREQ];
   int            s_addr  [NREQ];
   logic [DW-1:0] s_data  [NREQ];

   int            m_ptr;
   int            m_defer;
   logic [DW-1:0] m_shadow [32];
   bit            rsp_v    [2];
   int            rsp_id   [2];
   logic [DW-1:0] rsp_data [2];

   int            e_ready;
   bit            e_wen;
   int            e_wad;
   logic [DW-1:0] e_din;
   bit            e_ren [2];
   int            e_rad [2];
   int            e_rid [2];
   bit            e_defer;
   int            e_first;

   task automatic drive();
      for (int j = 0; j < NREQ; j++) begin
         bus.req_valid[j]            = s_valid[j];
         bus.req_we[j]               = s_we[j];
         bus.req_addr[j*AW +: AW]    = AW'(s_addr[j]);
         bus.req_wdata[j*DW +: DW]   = s_data[j];
      end
   endtask

   task automatic clearStimulus();
      for (int j = 0; j < NREQ; j++) begin
         s_valid[j] = 1'b0;
         s_we[j]    = 1'b0;
         s_addr[j]  = 0;
         s_data[j]  = '0;
      end
      drive();
   endtask

   task automatic applyStimulus(input int i, input bit v, input bit we, input int addr,
                                input logic [DW-1:0] d);
      s_valid[i] = v;
      s_we[i]    = we;
      s_addr[i]  = addr;
      s_data[i]  = d;
      drive();
   endtask

   // Reference: list requesters in round-robin order, take the first writer, then the first
   // two readers not aimed at the write address; matching readers are deferred.
   task automatic modelCompute();
      int order[$];
      int reads[$];
      e_ready = 0;
      e_wen   = 1'b0;
      e_wad   = 0;
      e_din   = '0;
      e_defer = 1'b0;
      e_first = -1;
      for (int s = 0; s < 2; s++) begin
         e_ren[s] = 1'b0;
         e_rad[s] = 0;
         e_rid[s] = 0;
      end
      for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
      foreach (order[j]) begin
         int r = order[j];
         if (!e_wen && s_valid[r] && s_we[r]) begin
            e_wen   = 1'b1;
            e_wad   = s_addr[r];
            e_din   = s_data[r];
            e_ready = e_ready | (1 << r);
         end
      end
      foreach (order[j]) begin
         int r = order[j];
         if (s_valid[r] && !s_we[r]) begin
            if (e_wen && (s_addr[r] == e_wad)) e_defer = 1'b1;
            else reads.push_back(r);
         end
      end
      for (int s = 0; s < 2; s++) begin
         if (s < reads.size()) begin
            e_ren[s] = 1'b1;
            e_rad[s] = s_addr[reads[s]];
            e_rid[s] = reads[s];
            e_ready  = e_ready | (1 << reads[s]);
         end
      end
      foreach (order[j]) begin
         if ((e_first < 0) && (((e_ready >> order[j]) & 1) == 1)) e_first = order[j];
      end
   endtask

   task automatic modelCommit();
      for (int s = 0; s < 2; s++) begin
         rsp_v[s]    = e_ren[s];
         rsp_id[s]   = e_rid[s];
         rsp_data[s] = m_shadow[e_rad[s]];
      end
      if (e_wen) m_shadow[e_wad] = e_din;
      if (e_defer && (m_defer < 65535)) m_defer++;
      if (e_first >= 0) m_ptr = (e_first + 1) % NREQ;
   endtask

   task automatic modelReset();
      m_ptr   = 0;
      m_defer = 0;
      rsp_v[0] = 1'b0;
      rsp_v[1] = 1'b0;
   endtask

   task automatic advance();
      modelCommit();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      clearStimulus();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clearStimulus();
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wen, bus.mem_ren1, bus.mem_ren2} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_grants actual=%b expected=0", {bus.req_ready, bus.mem_wen, bus.mem_ren1, bus.mem_ren2});
      end
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data} !== 34'b0) begin
         failures++;
         $display("[TB] FAIL reset_rsp actual=%h expected=0", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data});
      end
      checks++;
      if ({bus.defer_cnt, bus.err_collision} !== 17'b0) begin
         failures++;
         $display("[TB] FAIL reset_status actual=%h expected=0", {bus.defer_cnt, bus.err_collision});
      end
      resetn = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wen, bus.mem_ren1, bus.mem_ren2, bus.rsp0_valid, bus.rsp1_valid, bus.defer_cnt} !== 25'b0) begin
         failures++;
         $display("[TB] FAIL post_reset_idle actual=%h expected=0", {bus.req_ready, bus.mem_wen, bus.mem_ren1, bus.mem_ren2, bus.rsp0_valid, bus.rsp1_valid, bus.defer_cnt});
      end
      advance();
   endtask

   task automatic test_unwritten_read();
      clearStimulus();
      applyStimulus(0, 1'b1, 1'b0, 3, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_ren1, bus.mem_rad1} !== {4'b0001, 1'b1, 5'd3}) begin
         failures++;
         $display("[TB] FAIL unwritten_grant actual=%b expected=%b", {bus.req_ready, bus.mem_ren1, bus.mem_rad1}, {4'b0001, 1'b1, 5'd3});
      end
      advance();
      clearStimulus();
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data} !== {1'b1, 3'd0, 16'h0000}) begin
         failures++;
         $display("[TB] FAIL unwritten_rsp actual=%h expected=%h", {bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data}, {1'b1, 3'd0, 16'h0000});
      end
      advance();
   endtask

   task automatic test_write_then_read();
      clearStimulus();
      applyStimulus(0, 1'b1, 1'b1, 7, 16'hA5A5);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_din} !== {4'b0001, 1'b1, 5'd7, 16'hA5A5}) begin
         failures++;
         $display("[TB] FAIL wr_grant actual=%h expected=%h", {bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_din}, {4'b0001, 1'b1, 5'd7, 16'hA5A5});
      end
      advance();
      clearStimulus();
      applyStimulus(1, 1'b1, 1'b0, 7, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_ren1, bus.mem_rad1, bus.mem_wen} !== {4'b0010, 1'b1, 5'd7, 1'b0}) begin
         failures++;
         $display("[TB] FAIL rd_grant actual=%b expected=%b", {bus.req_ready, bus.mem_ren1, bus.mem_rad1, bus.mem_wen}, {4'b0010, 1'b1, 5'd7, 1'b0});
      end
      advance();
      clearStimulus();
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.rsp1_valid} !== {1'b1, 3'd1, 16'hA5A5, 1'b0}) begin
         failures++;
         $display("[TB] FAIL wr_rd_rsp actual=%h expected=%h", {bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.rsp1_valid}, {1'b1, 3'd1, 16'hA5A5, 1'b0});
      end
      advance();
   endtask

   task automatic test_conflict_defer();
      clearStimulus();
      applyStimulus(0, 1'b1, 1'b1, 4, 16'hFFFF);
      applyStimulus(1, 1'b1, 1'b0, 4, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_ren1, bus.mem_ren2} !== {4'b0001, 1'b1, 5'd4, 2'b00}) begin
         failures++;
         $display("[TB] FAIL conflict_grant actual=%b expected=%b", {bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_ren1, bus.mem_ren2}, {4'b0001, 1'b1, 5'd4, 2'b00});
      end
      advance();
      clearStimulus();
      applyStimulus(1, 1'b1, 1'b0, 4, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if (bus.defer_cnt !== 16'd1) begin
         failures++;
         $display("[TB] FAIL conflict_defer_cnt actual=%0d expected=1", bus.defer_cnt);
      end
      checks++;
      if ({bus.req_ready, bus.mem_ren1, bus.mem_rad1} !== {4'b0010, 1'b1, 5'd4}) begin
         failures++;
         $display("[TB] FAIL conflict_retry actual=%b expected=%b", {bus.req_ready, bus.mem_ren1, bus.mem_rad1}, {4'b0010, 1'b1, 5'd4});
      end
      advance();
      clearStimulus();
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.err_collision} !== {1'b1, 3'd1, 16'hFFFF, 1'b0}) begin
         failures++;
         $display("[TB] FAIL conflict_rsp actual=%h expected=%h", {bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.err_collision}, {1'b1, 3'd1, 16'hFFFF, 1'b0});
      end
      advance();
   endtask

   task automatic test_full_parallel();
      applyReset();
      applyStimulus(0, 1'b1, 1'b1, 1, 16'h0101);
      applyStimulus(1, 1'b1, 1'b0, 2, '0);
      applyStimulus(2, 1'b1, 1'b0, 3, '0);
      applyStimulus(3, 1'b1, 1'b0, 5, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_ren1, bus.mem_rad1, bus.mem_ren2, bus.mem_rad2} !==
          {4'b0111, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3}) begin
         failures++;
         $display("[TB] FAIL parallel_grant actual=%b expected=%b", {bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_ren1, bus.mem_rad1, bus.mem_ren2, bus.mem_rad2}, {4'b0111, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3});
      end
      advance();
      clearStimulus();
      applyStimulus(3, 1'b1, 1'b0, 5, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_ren1, bus.mem_rad1} !== {4'b1000, 1'b1, 5'd5}) begin
         failures++;
         $display("[TB] FAIL parallel_next actual=%b expected=%b", {bus.req_ready, bus.mem_ren1, bus.mem_rad1}, {4'b1000, 1'b1, 5'd5});
      end
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_id, bus.rsp1_data} !==
          {1'b1, 3'd1, rsp_data[0], 1'b1, 3'd2, rsp_data[1]}) begin
         failures++;
         $display("[TB] FAIL parallel_rsp actual=%h expected=%h", {bus.rsp0_valid, bus.rsp0_id, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_id, bus.rsp1_data}, {1'b1, 3'd1, rsp_data[0], 1'b1, 3'd2, rsp_data[1]});
      end
      advance();
      clearStimulus();
   endtask

   task automatic test_fairness();
      int grants [NREQ];
      int waits  [NREQ];
      int max_wait = 0;
      for (int j = 0; j < NREQ; j++) begin
         grants[j] = 0;
         waits[j]  = 0;
         applyStimulus(j, 1'b1, 1'b0, 10 + j, '0);
      end
      for (int c = 0; c < 8; c++) begin
         modelCompute();
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 4'(e_ready)) begin
            failures++;
            $display("[TB] FAIL fair_ready cycle=%0d actual=%b expected=%b", c, bus.req_ready, 4'(e_ready));
         end
         for (int j = 0; j < NREQ; j++) begin
            if (bus.req_ready[j]) begin
               grants[j]++;
               waits[j] = 0;
            end else begin
               waits[j]++;
               if (waits[j] > max_wait) max_wait = waits[j];
            end
         end
         advance();
      end
      for (int j = 0; j < NREQ; j++) begin
         checks++;
         if (grants[j] !== 4) begin
            failures++;
            $display("[TB] FAIL fair_count req=%0d actual=%0d expected=4", j, grants[j]);
         end
      end
      checks++;
      if (max_wait > 2) begin
         failures++;
         $display("[TB] FAIL fair_max_wait actual=%0d expected<=2", max_wait);
      end
      clearStimulus();
   endtask

   task automatic test_reset_midflight();
      clearStimulus();
      applyStimulus(0, 1'b1, 1'b1, 9, 16'h1234);
      applyStimulus(1, 1'b1, 1'b0, 9, '0);
      modelCompute();
      @(negedge clk);
      advance();
      clearStimulus();
      applyStimulus(2, 1'b1, 1'b0, 10, '0);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_ren1} !== {4'b0100, 1'b1}) begin
         failures++;
         $display("[TB] FAIL midflight_grant actual=%b expected=%b", {bus.req_ready, bus.mem_ren1}, {4'b0100, 1'b1});
      end
      advance();
      clearStimulus();
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_id, bus.defer_cnt} !== {1'b1, 3'd2, 16'd1}) begin
         failures++;
         $display("[TB] FAIL midflight_pre actual=%h expected=%h", {bus.rsp0_valid, bus.rsp0_id, bus.defer_cnt}, {1'b1, 3'd2, 16'd1});
      end
      #1;
      resetn = 1'b0;
      #1;
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.defer_cnt} !== 34'b0) begin
         failures++;
         $display("[TB] FAIL midflight_async actual=%h expected=0", {bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.defer_cnt});
      end
      @(negedge clk);
      resetn = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      applyStimulus(1, 1'b1, 1'b1, 20, 16'h2020);
      applyStimulus(3, 1'b1, 1'b1, 21, 16'h2121);
      modelCompute();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_wad} !== {4'b0010, 5'd20}) begin
         failures++;
         $display("[TB] FAIL midflight_ptr actual=%b expected=%b", {bus.req_ready, bus.mem_wad}, {4'b0010, 5'd20});
      end
      advance();
      clearStimulus();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int j = 0; j < NREQ; j++) begin
            applyStimulus(j, ($urandom_range(0, 9) < 7), $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 7)), DW'($urandom));
         end
         modelCompute();
         @(negedge clk);
         checks++;
         if ({bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_din} !== {4'(e_ready), e_wen, AW'(e_wad), e_din}) begin
            failures++;
            $display("[TB] FAIL rand_write cycle=%0d actual=%h expected=%h", c, {bus.req_ready, bus.mem_wen, bus.mem_wad, bus.mem_din}, {4'(e_ready), e_wen, AW'(e_wad), e_din});
         end
         checks++;
         if ({bus.mem_ren1, bus.mem_rad1, bus.mem_ren2, bus.mem_rad2} !== {e_ren[0], AW'(e_rad[0]), e_ren[1], AW'(e_rad[1])}) begin
            failures++;
            $display("[TB] FAIL rand_reads cycle=%0d actual=%b expected=%b", c, {bus.mem_ren1, bus.mem_rad1, bus.mem_ren2, bus.mem_rad2}, {e_ren[0], AW'(e_rad[0]), e_ren[1], AW'(e_rad[1])});
         end
         checks++;
         if ({bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_data} !==
             {rsp_v[0], rsp_v[0] ? rsp_data[0] : 16'h0, rsp_v[1], rsp_v[1] ? rsp_data[1] : 16'h0}) begin
            failures++;
            $display("[TB] FAIL rand_rsp_data cycle=%0d actual=%h expected=%h", c, {bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_data}, {rsp_v[0], rsp_v[0] ? rsp_data[0] : 16'h0, rsp_v[1], rsp_v[1] ? rsp_data[1] : 16'h0});
         end
         checks++;
         if ((rsp_v[0] && (bus.rsp0_id !== IDW'(rsp_id[0]))) || (rsp_v[1] && (bus.rsp1_id !== IDW'(rsp_id[1])))) begin
            failures++;
            $display("[TB] FAIL rand_rsp_id cycle=%0d actual=%0d/%0d expected=%0d/%0d", c, bus.rsp0_id, bus.rsp1_id, rsp_id[0], rsp_id[1]);
         end
         checks++;
         if ({bus.defer_cnt, bus.err_collision} !== {16'(m_defer), 1'b0}) begin
            failures++;
            $display("[TB] FAIL rand_status cycle=%0d actual=%h expected=%h", c, {bus.defer_cnt, bus.err_collision}, {16'(m_defer), 1'b0});
         end
         advance();
      end
      clearStimulus();
   endtask

   initial begin
      for (int a = 0; a < 32; a++) m_shadow[a] = '0;
      modelReset();
      test_reset();
      test_unwritten_read();
      test_write_then_read();
      test_conflict_defer();
      test_full_parallel();
      test_fairness();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
